// File: rtl/param_syncfifo.sv
// param_syncfifo: single-clock FIFO with first-word fall-through output,
// occupancy and threshold flags, and sticky overflow/underflow flags.
`timescale 1ns/1ps
module param_syncfifo #(
   parameter type dat_t     = logic [7:0],
   parameter int  DEPTH     = 8,
   parameter int  AFULL_TH  = DEPTH - 2,
   parameter int  AEMPTY_TH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  dat_t                   wdata,
   input  logic                   wput,
   output logic                   wrdy,
   output dat_t                   rdata,
   input  logic                   rget,
   output logic                   rrdy,
   output logic [$clog2(DEPTH):0] count,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   ovf,
   output logic                   udf,
   input  logic                   flag_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   dat_t          mem [DEPTH];
   logic          wacc;
   logic          racc;

   // Ready flags come from registered count only, so no request-to-ready path.
   assign wrdy = (count < CW'(DEPTH));
   assign rrdy = (count != '0);

   assign wacc = wput && wrdy;
   assign racc = rget && rrdy;

   // Empty FIFO shows zero so stale storage is never visible.
   assign rdata = rrdy ? mem[rptr] : '0;

   assign almost_full  = (count >= CW'(AFULL_TH));
   assign almost_empty = (count <= CW'(AEMPTY_TH));

   // Storage write; contents need no reset because rdata is masked when empty.
   always_ff @(posedge clk) begin
      if (wacc) begin
         mem[wptr] <= wdata;
      end
   end

   // Pointers advance on accepted transfers; power-of-two depth wraps freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wacc) begin
            wptr <= wptr + AW'(1);
         end
         if (racc) begin
            rptr <= rptr + AW'(1);
         end
      end
   end

   // Occupancy tracks the net of accepted writes and reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         unique case ({wacc, racc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new error in the clear cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wput && !wrdy) begin
            ovf <= 1'b1;
         end else if (flag_clr) begin
            ovf <= 1'b0;
         end
         if (rget && !rrdy) begin
            udf <= 1'b1;
         end else if (flag_clr) begin
            udf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_param_syncfifo.sv
// tb_param_syncfifo: scoreboard bench for param_syncfifo with a
// queue-based reference model, directed corner cases and random traffic.
`timescale 1ns/1ps
module tb_param_syncfifo;

   localparam int DEPTH = 8;
   localparam int AFT   = 6;
   localparam int AET   = 2;

   logic       clk;
   logic       rst_n;
   logic [7:0] wdata;
   logic       wput;
   logic       wrdy;
   logic [7:0] rdata;
   logic       rget;
   logic       rrdy;
   logic [3:0] count;
   logic       almost_full;
   logic       almost_empty;
   logic       ovf;
   logic       udf;
   logic       flag_clr;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q[$];
   logic [7:0] exp_q[$];
   bit         m_ovf;
   bit         m_udf;

   param_syncfifo #(
      .dat_t     (logic [7:0]),
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFT),
      .AEMPTY_TH (AET)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wdata        (wdata),
      .wput         (wput),
      .wrdy         (wrdy),
      .rdata        (rdata),
      .rget         (rget),
      .rrdy         (rrdy),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .ovf          (ovf),
      .udf          (udf),
      .flag_clr     (flag_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, expv, $time);
      end
   endtask

   task automatic check_state();
      int n;
      n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("wrdy", 32'(wrdy), 32'(n < DEPTH));
      chk("rrdy", 32'(rrdy), 32'(n != 0));
      chk("almost_full", 32'(almost_full), 32'(n >= AFT));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AET));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("udf", 32'(udf), 32'(m_udf));
      chk("rdata_head", 32'(rdata), (n != 0) ? 32'(q[0]) : 32'h0);
   endtask

   // One cycle: check settled state, then drive inputs and advance the model.
   task automatic step(input bit w, input bit r, input logic [7:0] d,
                       input bit c);
      bit wa;
      bit ra;
      logic [7:0] tmp;
      @(posedge clk);
      #1;
      check_state();
      wput     = w;
      rget     = r;
      wdata    = d;
      flag_clr = c;
      wa = w && (q.size() < DEPTH);
      ra = r && (q.size() > 0);
      if (ra) begin
         exp_q.push_back(q[0]);
         tmp = q.pop_front();
      end
      if (wa) q.push_back(d);
      if (w && !wa) m_ovf = 1'b1;
      else if (c)   m_ovf = 1'b0;
      if (r && !ra) m_udf = 1'b1;
      else if (c)   m_udf = 1'b0;
   endtask

   // Monitor: every accepted read pops the scoreboard and compares data.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && rget && rrdy) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_read act=%0h exp=none", rdata);
            end else begin
               e = exp_q.pop_front();
               chk("sb_rdata", 32'(rdata), 32'(e));
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      wput     = 1'b0;
      rget     = 1'b0;
      wdata    = '0;
      flag_clr = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      #12;
      check_state();
      @(negedge clk);
      rst_n = 1'b1;

      // Fill 0x01..0x08, full with put+get of 0xAA, then drain.
      for (int i = 1; i <= DEPTH; i++) step(1, 0, 8'(i), 0);
      step(1, 1, 8'hAA, 0);
      while (q.size() > 0) step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Empty with put+get of 0x55, then clear sticky flags.
      step(1, 1, 8'h55, 0);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 1);
      step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Streaming: prefill one, then put and get every cycle across wraps.
      step(1, 0, 8'($urandom), 0);
      for (int i = 0; i < 20; i++) step(1, 1, 8'($urandom), 0);
      step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Random traffic with phases biased toward full and toward empty.
      for (int p = 0; p < 4; p++) begin
         int wp;
         int rp;
         wp = (p == 0) ? 85 : (p == 1) ? 15 : 50;
         rp = (p == 0) ? 15 : (p == 1) ? 85 : 50;
         for (int i = 0; i < 80; i++) begin
            step(32'($urandom_range(0, 99)) < 32'(wp),
                 32'($urandom_range(0, 99)) < 32'(rp),
                 8'($urandom),
                 $urandom_range(0, 15) == 0);
         end
      end

      // Bring occupancy to five, then reset asynchronously mid-operation.
      while (q.size() > 0) step(0, 1, 8'h00, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), 0);
      step(0, 0, 8'h00, 0);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check_state();
      @(negedge clk);
      rst_n = 1'b1;

      // Post-reset behaves as from empty.
      step(1, 1, 8'h3C, 0);
      for (int i = 0; i < 40; i++) begin
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              8'($urandom), 0);
      end
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
